// File: rtl/frequency_divider_by2_pkg.sv
// Shared constants and types for the synchronous divide-by-2 chain.
// Optional feature macro: FREQ_DIV_TICK_EN (adds tick_out).
package freq_div_pkg;

  localparam int FREQ_DIV_MAX_STAGES = 16;

  // Reset value of every stage flop.
  localparam logic FREQ_DIV_RST_VAL = 1'b0;

  // Tap vector at the maximum legal width; users slice [STAGES-1:0].
  typedef logic [FREQ_DIV_MAX_STAGES-1:0] freq_div_taps_t;

  // True when a requested stage count is within the supported range.
  function automatic bit freq_div_stages_ok(input int stages);
    return (stages >= 1) && (stages <= FREQ_DIV_MAX_STAGES);
  endfunction

endpackage

// File: rtl/frequency_divider_by2_if.sv
// Bundles the enable and the divided outputs of frequency_divider_by2.
// The divider is the slave (drives the taps), the consumer is the master.
// With FREQ_DIV_TICK_EN defined the bundle also carries tick_out.
interface frequency_divider_by2_if #(parameter int STAGES = 4);

  logic              en;
  logic              clk_out;
  logic [STAGES-1:0] div_taps;
`ifdef FREQ_DIV_TICK_EN
  logic              tick_out;

  modport slave  (input en, output clk_out, output div_taps, output tick_out);
  modport master (output en, input clk_out, input div_taps, input tick_out);
`else
  modport slave  (input en, output clk_out, output div_taps);
  modport master (output en, input clk_out, input div_taps);
`endif

endinterface

// File: rtl/frequency_divider_by2_stage.sv
// One toggle flop of the synchronous counter chain. It flips when enabled
// and every lower stage is 1 (carry_i), and forwards the carry upward.
module freq_div_stage
  import freq_div_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic carry_i,
  output logic q_o,
  output logic carry_o
);

  logic q_q, q_d;

  // Next state: toggle on an enabled edge with carry-in, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en_i && carry_i) q_d = ~q_q;
  end

  // Stage flop; reset overrides enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= FREQ_DIV_RST_VAL;
    else       q_q <= q_d;
  end

  assign q_o     = q_q;
  assign carry_o = carry_i & q_q;

endmodule

// File: rtl/frequency_divider_by2.sv
// Synchronous divide-by-2 with a chain of further /2 taps. Every flop runs
// on clk_in; the taps are data-rate signals, never used as clocks here.
// Optional feature macro: FREQ_DIV_TICK_EN (one-cycle tick on each
// 0->1 transition of clk_out).
module frequency_divider_by2
  import freq_div_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic                   clk_in,
  input  logic                   rst,
  frequency_divider_by2_if.slave bus
);

  // Carry chain: stage 0 always sees carry-in, stage k sees &q[k-1:0].
  logic [STAGES:0]   carry;
  logic [STAGES-1:0] q;
  logic              unused_carry;

  assign carry[0]     = 1'b1;
  assign unused_carry = carry[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    freq_div_stage u_stage (
      .clk_i   (clk_in),
      .rst_i   (rst),
      .en_i    (bus.en),
      .carry_i (carry[k]),
      .q_o     (q[k]),
      .carry_o (carry[k+1])
    );
  end

  assign bus.div_taps = q;
  assign bus.clk_out  = q[0];

`ifdef FREQ_DIV_TICK_EN
  logic tick_q, tick_d;

  // Tick fires on the enabled edge where stage 0 goes 0->1.
  always_comb begin
    tick_d = 1'b0;
    if (bus.en && !q[0]) tick_d = 1'b1;
  end

  // Tick flop, aligned with the clk_out rising transition.
  always_ff @(posedge clk_in) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= tick_d;
  end

  assign bus.tick_out = tick_q;
`endif

endmodule

// File: tb/tb_frequency_divider_by2.sv
// Directed self-checking bench for frequency_divider_by2 (STAGES=4).
// Define FREQ_DIV_TICK_EN to also exercise tick_out.
module tb_frequency_divider_by2;

  localparam int STAGES = 4;

  logic clk_in;
  logic rst;
  int   n_cmp;
  int   n_err;

  frequency_divider_by2_if #(.STAGES(STAGES)) bus ();

  frequency_divider_by2 #(.STAGES(STAGES)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  initial clk_in = 1'b0;
  always #10 clk_in = ~clk_in;

  // Advance one rising edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Hold reset for one edge with en high, then release.
  task automatic do_reset();
    rst    = 1'b1;
    bus.en = 1'b1;
    step();
    rst    = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (bus.div_taps !== 4'b0000 || bus.clk_out !== 1'b0) begin
        n_err++;
        $display("FAIL reset edge%0d: taps=%b clk_out=%b want 0000/0", i, bus.div_taps, bus.clk_out);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_divide();
    logic [3:0] exp;
    int rises;
    logic prev;
    do_reset();
    exp   = 4'd0;
    rises = 0;
    prev  = bus.clk_out;
    for (int i = 0; i < 32; i++) begin
      step();
      exp = exp + 4'd1;
      n_cmp++;
      if (bus.div_taps !== exp || bus.clk_out !== exp[0]) begin
        n_err++;
        $display("FAIL divide edge%0d: taps=%b clk_out=%b want %b/%b", i + 1, bus.div_taps, bus.clk_out, exp, exp[0]);
      end
      if (!prev && bus.clk_out === 1'b1) rises++;
      prev = bus.clk_out;
    end
    n_cmp++;
    if (rises !== 16) begin
      n_err++;
      $display("FAIL divide_periods: got %0d clk_out rises want 16", rises);
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (bus.div_taps !== 4'b0101) begin
      n_err++;
      $display("FAIL hold_setup: taps=%b want 0101", bus.div_taps);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (bus.div_taps !== 4'b0101 || bus.clk_out !== 1'b1) begin
        n_err++;
        $display("FAIL hold edge%0d: taps=%b clk_out=%b want 0101/1", i, bus.div_taps, bus.clk_out);
      end
    end
    bus.en = 1'b1;
    step();
    n_cmp++;
    if (bus.div_taps !== 4'b0110) begin
      n_err++;
      $display("FAIL hold_resume: taps=%b want 0110", bus.div_taps);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 11; i++) step();
    n_cmp++;
    if (bus.div_taps !== 4'b1011) begin
      n_err++;
      $display("FAIL midrst_setup: taps=%b want 1011", bus.div_taps);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (bus.div_taps !== 4'b0000 || bus.clk_out !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_clear: taps=%b clk_out=%b want 0000/0", bus.div_taps, bus.clk_out);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (bus.div_taps !== 4'b0001 || bus.clk_out !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_restart: taps=%b clk_out=%b want 0001/1", bus.div_taps, bus.clk_out);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) step();
    n_cmp++;
    if (bus.div_taps !== 4'b1111 || bus.clk_out !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_setup: taps=%b clk_out=%b want 1111/1", bus.div_taps, bus.clk_out);
    end
    step();
    n_cmp++;
    if (bus.div_taps !== 4'b0000 || bus.clk_out !== 1'b0) begin
      n_err++;
      $display("FAIL wrap: taps=%b clk_out=%b want 0000/0", bus.div_taps, bus.clk_out);
    end
  endtask

`ifdef FREQ_DIV_TICK_EN
  task automatic test_tick();
    logic exp;
    rst    = 1'b1;
    bus.en = 1'b1;
    step();
    n_cmp++;
    if (bus.tick_out !== 1'b0) begin
      n_err++;
      $display("FAIL tick_in_reset: tick=%b want 0", bus.tick_out);
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = (i % 2 == 1);
      n_cmp++;
      if (bus.tick_out !== exp) begin
        n_err++;
        $display("FAIL tick edge%0d: tick=%b want %b", i, bus.tick_out, exp);
      end
    end
    // count is 10 (q[0]=0): a tick would follow if enabled, so hold must suppress it
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus.tick_out !== 1'b0) begin
        n_err++;
        $display("FAIL tick_en_low%0d: tick=%b want 0", i, bus.tick_out);
      end
    end
    bus.en = 1'b1;
    rst    = 1'b1;
    step();
    n_cmp++;
    if (bus.tick_out !== 1'b0) begin
      n_err++;
      $display("FAIL tick_rst_wins: tick=%b want 0", bus.tick_out);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (bus.tick_out !== 1'b1) begin
      n_err++;
      $display("FAIL tick_after_rst: tick=%b want 1", bus.tick_out);
    end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    bus.en = 1'b0;
    @(negedge clk_in);
    test_reset();
    test_basic_divide();
    test_enable_hold();
    test_reset_mid();
    test_wrap();
`ifdef FREQ_DIV_TICK_EN
    test_tick();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frequency_divider_by2.md
Name: frequency_divider_by2

Overview:
- Synchronous divide-by-2 clock divider.
- Produces clk_out at half the frequency of clk_in with a 50% duty cycle.
- Also exposes a parameterised chain of further /2 taps for slower housekeeping rates.
- All state is clocked by clk_in only. Derived outputs are never used as clocks inside the block, so there are no ripple stages.

Parameters:
- STAGES, 4, number of cascaded /2 stages; tap k toggles at clk_in/2^(k+1); legal range 1..16.

Ports:
- clk_in  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the clk_in rising edge.
- en  input  1  count enable; when low, all outputs hold.
- clk_out  output  1  clk_in/2 square wave; equals div_taps[0].
- div_taps  output  STAGES  tap k is a clk_in/2^(k+1) square wave, 50% duty.

Behaviour:
- State: STAGES-bit register q, one bit per stage, all in the clk_in domain.
- Reset: on a clk_in rising edge with rst=1, q <= 0, so clk_out=0 and div_taps=0. rst overrides en.
- Outputs are undefined until the first clk_in rising edge with rst=1. A bench must clock at least one edge during reset.
- Stage 0: on each rising edge with rst=0 and en=1, q[0] <= ~q[0].
- Stage k>0: on each rising edge with rst=0 and en=1, q[k] toggles when q[k-1:0] are all 1 (synchronous binary increment).
- Latency: clk_out changes on every qualifying rising edge, registered with 1 clk_in edge of latency.
  - First edge after reset release gives clk_out=1.
  - clk_out period = 2 clk_in periods, high for exactly 1.
- Wrap-around: when q is all ones, the next enabled edge returns q to all zeros. No sticky state.
- en=0: q holds. The phase relationship resumes exactly where it stopped; no extra toggle on re-enable.
- Reset mid-operation: the next edge with rst=1 forces q=0 regardless of phase. After release, the sequence restarts from 0.
- Simultaneous rst=1 and en=1: reset wins.
- Outputs are driven directly from flops; no combinational path from any input to any output.
- clk_out and div_taps are data-rate signals. Consumers that need them as clocks must route them through the clock-gating/buffer cells owned by the clocking block.

Optional Feature:
- Macro: FREQ_DIV_TICK_EN.
- Defined: adds output tick_out (1 bit, registered). It is high for exactly one clk_in cycle on each edge where clk_out goes 0->1, i.e. once every 2 enabled cycles.
  - tick_out=0 in reset and while en=0.
  - Rising-edge-of-clk_out detection is done in the clk_in domain.
- Not defined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package freq_div_pkg:
  - constant FREQ_DIV_MAX_STAGES = 16;
  - typedef for the tap vector width derived from STAGES;
  - reset value constant FREQ_DIV_RST_VAL = 0.
- One natural sub-module: freq_div_stage.
  - Single toggle flop with rst, en and carry-in; produces its output bit and carry-out.
  - Instantiated STAGES times via generate; the top wires the carry chain and the optional tick logic.

Test Plan:
- Reset: rst=1 for 2 clk_in edges with en=1 -> clk_out=0 and div_taps=4'b0000 after the first edge.
- Basic divide: release rst, en=1, 32 clk_in cycles (10 ns half-period).
  - clk_out toggles each rising edge, sequence 1,0,1,0...
  - Period 40 ns; 16 full clk_out periods.
  - div_taps counts 1,2,...,15,0,1... (STAGES=4).
- Enable hold: en=0 for 5 edges when div_taps=4'b0101 -> stays 0101. After en=1, the next edge gives 0110.
- Reset mid-run: assert rst for 1 edge when div_taps=4'b1011 -> 0000 on that edge. The next enabled edge gives 0001 and clk_out=1.
- Wrap: from 4'b1111 with en=1 -> 0000 on the next edge; clk_out goes 1->0.
- FREQ_DIV_TICK_EN defined: 10 enabled edges after reset -> tick_out pulses on edges 1,3,5,7,9, one cycle wide each. No pulse while en=0 or rst=1.
